// File: rtl/ad_capture_pkg.sv
// Shared types, sizes and sample helpers for the ADC capture stage.
package ad_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE
  } state_t;

  localparam int unsigned SAMP_W   = 8;
  localparam int unsigned SYM_LEN  = 64;
  localparam int unsigned WIN_LOG2 = 4;
  localparam int unsigned WIN_LEN  = 1 << WIN_LOG2;
  localparam int unsigned MAG_W    = 9;
  localparam int unsigned ENERGY_W = 13;
  localparam int unsigned CNT_W    = 14;

  function automatic logic [SAMP_W-1:0] ob_to_tc(input logic [SAMP_W-1:0] raw);
    return {~raw[SAMP_W-1], raw[SAMP_W-2:0]};
  endfunction

  // -128 maps to 128, which still fits the unsigned 8-bit result
  function automatic logic [SAMP_W-1:0] abs_tc(input logic [SAMP_W-1:0] v);
    return v[SAMP_W-1] ? SAMP_W'(~v + 8'd1) : v;
  endfunction

  function automatic logic [MAG_W-1:0] magnitude(input logic [SAMP_W-1:0] i,
                                                 input logic [SAMP_W-1:0] q);
    return {1'b0, abs_tc(i)} + {1'b0, abs_tc(q)};
  endfunction

  function automatic logic is_extreme(input logic [SAMP_W-1:0] raw);
    return (raw == '0) || (raw == '1);
  endfunction

endpackage

// File: rtl/ad_capture_if.sv
// Sample bus: raw ADC samples in, converted samples out to the receive chain.
interface ad_capture_if;
  logic [7:0] adc_i;
  logic [7:0] adc_q;
  logic       adc_strobe;
  logic [7:0] ad1;
  logic [7:0] ad2;
  logic       ad_valid;

  modport master (
    output adc_i, adc_q, adc_strobe,
    input  ad1, ad2, ad_valid
  );

  modport slave (
    input  adc_i, adc_q, adc_strobe,
    output ad1, ad2, ad_valid
  );
endinterface

// File: rtl/ad_energy_win.sv
// Sliding 16-sample energy window: shift register of magnitudes plus running sum.
module ad_energy_win
  import ad_capture_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic                i_strobe,
  input  logic [MAG_W-1:0]    i_mag,
  output logic [ENERGY_W-1:0] o_energy,
  output logic                o_valid
);

  logic [MAG_W-1:0]    r_win [WIN_LEN];
  logic [ENERGY_W-1:0] r_energy;
  logic [WIN_LOG2:0]   r_fill;
  logic [ENERGY_W-1:0] w_sum;

  // Oldest magnitude leaves as the new one enters; the sum never exceeds 4096
  assign w_sum    = r_energy + ENERGY_W'(i_mag) - ENERGY_W'(r_win[WIN_LEN-1]);
  assign o_energy = i_strobe ? w_sum : r_energy;
  assign o_valid  = r_fill[WIN_LOG2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < WIN_LEN; k++) r_win[k] <= '0;
      r_energy <= '0;
      r_fill   <= '0;
    end else if (i_clear) begin
      for (int unsigned k = 0; k < WIN_LEN; k++) r_win[k] <= '0;
      r_energy <= '0;
      r_fill   <= '0;
    end else if (i_strobe) begin
      r_win[0] <= i_mag;
      for (int unsigned k = 1; k < WIN_LEN; k++) r_win[k] <= r_win[k-1];
      r_energy <= w_sum;
      if (!r_fill[WIN_LOG2]) r_fill <= r_fill + 5'd1;
    end
  end

endmodule

// File: rtl/ad_capture.sv
// ADC capture: offset-binary to two's complement, energy burst detect, NSYM*64 sample frame.
// Optional AD_CAPTURE_AUTOREARM_EN: return to ARMED instead of IDLE after each frame.
module ad_capture
  import ad_capture_pkg::*;
#(
  parameter int unsigned NSYM   = 16,
  parameter int unsigned THRESH = 64
) (
  input  logic               CLK,
  input  logic               RST,
  ad_capture_if.slave        ad_bus,
  input  logic               arm,
  output logic               busy,
  output logic               frame_done,
  output logic               overrange
);

  localparam logic [CNT_W-1:0]    LAST = CNT_W'(NSYM * SYM_LEN - 1);
  localparam logic [ENERGY_W-1:0] THR  = ENERGY_W'(THRESH);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [SAMP_W-1:0]   r_ad1, r_ad2;
  logic                r_ad_valid, r_busy, r_frame_done, r_overrange;

  logic [SAMP_W-1:0]   w_i_tc, w_q_tc;
  logic [MAG_W-1:0]    w_mag;
  logic [ENERGY_W-1:0] w_energy;
  logic                w_win_valid, w_win_stb, w_trigger, w_ovr_hit;
  logic                w_emit, w_done, w_clear, w_arm_ok;

  assign w_i_tc    = ob_to_tc(ad_bus.adc_i);
  assign w_q_tc    = ob_to_tc(ad_bus.adc_q);
  assign w_mag     = magnitude(w_i_tc, w_q_tc);
  assign w_win_stb = ad_bus.adc_strobe && (r_state == ST_ARMED);
  assign w_trigger = w_win_stb && w_win_valid && (w_energy > THR);
  assign w_ovr_hit = ad_bus.adc_strobe && (r_state == ST_CAPTURE) &&
                     (is_extreme(ad_bus.adc_i) || is_extreme(ad_bus.adc_q));

  ad_energy_win u_win (
    .clk      (CLK),
    .rst_n    (RST),
    .i_clear  (w_clear),
    .i_strobe (w_win_stb),
    .i_mag    (w_mag),
    .o_energy (w_energy),
    .o_valid  (w_win_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;
    w_done      = 1'b0;
    w_clear     = 1'b0;
    w_arm_ok    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clear = 1'b1;
        if (arm) begin
          w_arm_ok    = 1'b1;
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // The triggering strobe is itself sample 0 of the frame
        if (w_trigger) begin
          w_emit      = 1'b1;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (ad_bus.adc_strobe) begin
          w_emit = 1'b1;
          if (r_cnt == LAST) begin
            w_done    = 1'b1;
            w_cnt_nxt = '0;
`ifdef AD_CAPTURE_AUTOREARM_EN
            w_clear     = 1'b1;
            w_state_nxt = ST_ARMED;
`else
            w_state_nxt = ST_IDLE;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_ad1        <= '0;
      r_ad2        <= '0;
      r_ad_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrange  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ad_valid   <= w_emit;
      r_frame_done <= w_done;
      r_busy       <= (w_state_nxt != ST_IDLE);
      if (w_emit) begin
        r_ad1 <= w_i_tc;
        r_ad2 <= w_q_tc;
      end
      if (w_arm_ok)       r_overrange <= 1'b0;
      else if (w_ovr_hit) r_overrange <= 1'b1;
    end
  end

  assign ad_bus.ad1      = r_ad1;
  assign ad_bus.ad2      = r_ad2;
  assign ad_bus.ad_valid = r_ad_valid;
  assign busy            = r_busy;
  assign frame_done      = r_frame_done;
  assign overrange       = r_overrange;

endmodule

// File: tb/tb_ad_capture.sv
// Directed bench for ad_capture (NSYM=2, THRESH=64): detection, frame length, overrange, reset abort.
module tb_ad_capture;

`ifdef AD_CAPTURE_AUTOREARM_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic arm;
  logic busy, frame_done, overrange;
  int   total = 0;
  int   bad   = 0;
  int   vcnt  = 0;
  int   dcnt  = 0;
  int   v0, d0;
  logic [7:0] iv, qv;

  ad_capture_if bus ();

  ad_capture #(.NSYM(2), .THRESH(64)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .ad_bus     (bus),
    .arm        (arm),
    .busy       (busy),
    .frame_done (frame_done),
    .overrange  (overrange)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ad_valid === 1'b1) vcnt++;
    if (frame_done === 1'b1)   dcnt++;
  end

  typedef struct {
    logic       a;
    logic       s;
    logic [7:0] i;
    logic [7:0] q;
    logic       ev;
    logic [7:0] e1;
    logic [7:0] e2;
    logic       eb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic a, input logic s, input logic [7:0] i,
                              input logic [7:0] q, input logic ev, input logic [7:0] e1,
                              input logic [7:0] e2, input logic eb);
    vec_t v;
    v.a = a; v.s = s; v.i = i; v.q = q;
    v.ev = ev; v.e1 = e1; v.e2 = e2; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic a, input logic s, input logic [7:0] i, input logic [7:0] q);
    arm            = a;
    bus.adc_strobe = s;
    bus.adc_i      = i;
    bus.adc_q      = q;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_tbl(input string tag);
    foreach (tbl[n]) begin
      drive(tbl[n].a, tbl[n].s, tbl[n].i, tbl[n].q);
      tick();
      chk($sformatf("%s[%0d].valid", tag, n), bus.ad_valid, tbl[n].ev);
      chk($sformatf("%s[%0d].busy", tag, n), busy, tbl[n].eb);
      chk($sformatf("%s[%0d].done", tag, n), frame_done, 1'b0);
      if (tbl[n].ev) begin
        chk($sformatf("%s[%0d].ad1", tag, n), bus.ad1, tbl[n].e1);
        chk($sformatf("%s[%0d].ad2", tag, n), bus.ad2, tbl[n].e2);
      end
    end
    tbl.delete();
    drive(1'b0, 1'b0, 8'h80, 8'h80);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 8'h80, 8'h80);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", bus.ad_valid, 1'b0);
    chk("rst.ad1", bus.ad1, 8'h00);
    chk("rst.ad2", bus.ad2, 8'h00);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", frame_done, 1'b0);
    chk("rst.ovr", overrange, 1'b0);
    rst_n = 1'b1;
    tick();

    // Burst A: silence, noise landing exactly on the threshold, then one step above
    v0 = vcnt; d0 = dcnt;
    tbl.push_back(mk(1'b1, 1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 8'h00, 1'b1));
    for (int n = 0; n < 20; n++) tbl.push_back(mk(1'b0, 1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 8'h00, 1'b1));
    for (int n = 0; n < 16; n++) tbl.push_back(mk(1'b0, 1'b1, 8'h82, 8'h7E, 1'b0, 8'h00, 8'h00, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h83, 8'h7E, 1'b1, 8'h03, 8'hFE, 1'b1));
    run_tbl("armA");

    for (int k = 1; k < 128; k++) begin
      iv = (k == 40) ? 8'hFF : 8'h40 + 8'(k % 64);
      qv = 8'hA0 - 8'(k % 64);
      drive(k == 127, 1'b1, iv, qv);
      tick();
      chk($sformatf("capA[%0d].valid", k), bus.ad_valid, 1'b1);
      chk($sformatf("capA[%0d].ad1", k), bus.ad1, iv ^ 8'h80);
      chk($sformatf("capA[%0d].ad2", k), bus.ad2, qv ^ 8'h80);
      chk($sformatf("capA[%0d].done", k), frame_done, k == 127);
      chk($sformatf("capA[%0d].busy", k), busy, (k == 127) ? AUTO : 1'b1);
      chk($sformatf("capA[%0d].ovr", k), overrange, k >= 40);
    end
    drive(1'b0, 1'b0, 8'h80, 8'h80);
    tick();
    chk("postA.valid", bus.ad_valid, 1'b0);
    chk("postA.done", frame_done, 1'b0);
    chk("postA.busy", busy, AUTO);
    chk("postA.ovr", overrange, 1'b1);
    chk("postA.nvalid", vcnt - v0, 128);
    chk("postA.ndone", dcnt - d0, 1);

    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 1'b1, 8'h80, 8'h80);
      tick();
      chk($sformatf("gap[%0d].valid", n), bus.ad_valid, 1'b0);
      chk($sformatf("gap[%0d].ovr", n), overrange, 1'b1);
      chk($sformatf("gap[%0d].busy", n), busy, AUTO);
    end
    drive(1'b1, 1'b0, 8'h80, 8'h80);
    tick();
    chk("armB.busy", busy, 1'b1);
    chk("armB.ovr", overrange, AUTO);

    // Burst B: silence then a constant tone of magnitude 128
    for (int n = 0; n < 16; n++) tbl.push_back(mk(1'b0, 1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 8'h00, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 8'hC0, 8'hC0, 1'b1, 8'h40, 8'h40, 1'b1));
    run_tbl("armB");

    for (int n = 1; n < 50; n++) begin
      iv = 8'h10 + 8'(n);
      qv = 8'hF0 - 8'(n);
      drive(1'b0, 1'b1, iv, qv);
      tick();
      chk($sformatf("capB[%0d].valid", n), bus.ad_valid, 1'b1);
      chk($sformatf("capB[%0d].ad1", n), bus.ad1, iv ^ 8'h80);
      chk($sformatf("capB[%0d].ad2", n), bus.ad2, qv ^ 8'h80);
      if (n <= 10) begin
        drive(1'b0, 1'b0, iv, qv);
        tick();
        chk($sformatf("capB[%0d].hole", n), bus.ad_valid, 1'b0);
      end
    end

    // Asynchronous reset while sample 50 is on the bus
    drive(1'b0, 1'b1, 8'h55, 8'h55);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", bus.ad_valid, 1'b0);
    chk("arst.ad1", bus.ad1, 8'h00);
    chk("arst.ad2", bus.ad2, 8'h00);
    chk("arst.busy", busy, 1'b0);
    chk("arst.done", frame_done, 1'b0);
    chk("arst.ovr", overrange, 1'b0);
    tick();
    rst_n = 1'b1;
    v0 = vcnt; d0 = dcnt;
    for (int n = 0; n < 140; n++) begin
      drive(1'b0, 1'b1, 8'hC0, 8'hC0);
      tick();
    end
    chk("post_rst.nvalid", vcnt - v0, 0);
    chk("post_rst.ndone", dcnt - d0, 0);
    chk("post_rst.busy", busy, 1'b0);
    drive(1'b1, 1'b0, 8'h80, 8'h80);
    tick();
    chk("post_rst.arm_busy", busy, 1'b1);
    drive(1'b0, 1'b0, 8'h80, 8'h80);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ad_capture.md
# ad_capture

ADC front-end capture stage that drives the receive chain's `ad1`/`ad2`/`ad_valid` inputs. It converts raw offset-binary I/Q samples to two's complement and runs a sliding-window energy detector to find the start of a burst. Once a burst is detected, it forwards exactly `NSYM` × 64 samples, one OFDM frame of whole FFT chunks, then stops. Outside a capture window, no samples reach the rescale/FIFO/FFT path.

## Interface
- `NSYM`, default 16: 64-sample symbols per frame; legal 1..256.
- `THRESH`, default 64: energy threshold; detection when window energy > `THRESH`; 13-bit unsigned.
- `CLK` in 1: single clock.
- `RST` in 1: reset, asynchronous, active-low.
- `adc_i` in 8: raw I sample, offset binary.
- `adc_q` in 8: raw Q sample, offset binary.
- `adc_strobe` in 1: new sample present on `adc_i`/`adc_q` this cycle; may be high every cycle.
- `arm` in 1: single-cycle request to start searching for a burst.
- `ad1` out 8: I sample, two's complement, to receive chain.
- `ad2` out 8: Q sample, two's complement.
- `ad_valid` out 1: `ad1`/`ad2` valid this cycle.
- `busy` out 1: high in ARMED or CAPTURE.
- `frame_done` out 1: one-cycle pulse on the last sample of a frame.
- `overrange` out 1: sticky flag; an ADC code of 0x00 or 0xFF was seen during CAPTURE.

## Operation
- Conversion: invert the MSB of each raw code (0x80 → 0, 0x00 → −128, 0xFF → +127).
- Magnitude per sample is |i|+|q| on the converted values.
  - Each abs is 8-bit unsigned; −128 maps to 128.
  - The sum is 9 bits, max 256.
- Energy is the sum of the last 16 magnitudes, 13 bits, max 4096, no saturation needed.
  - It updates only on `adc_strobe`.
  - A fill counter marks the window valid after 16 strobes.
- FSM states:
  - IDLE: outputs quiet, window held cleared. `arm` → ARMED, and clears the window, fill counter and `overrange`.
  - ARMED: window accumulates. On a strobe where the window is valid and the updated energy > `THRESH` → CAPTURE. The triggering sample is emitted and counts as sample 0.
  - CAPTURE: every strobe emits one sample and increments the sample counter (14 bits). The strobe carrying sample `NSYM`×64−1 emits it, pulses `frame_done` and leaves CAPTURE.
  - Exit from CAPTURE depends on configuration (see Configuration).
- `arm` outside IDLE is ignored. `arm` coincident with the CAPTURE exit is also ignored.
- Strobes in IDLE are discarded. Strobes in ARMED feed the window only and are not emitted.
- `overrange` sets on any CAPTURE strobe with a raw code of 0x00 or 0xFF on either channel. It holds until the next accepted `arm`.
- Reset during CAPTURE abandons the frame: no `frame_done` and no further `ad_valid`. Downstream sees a short chunk; frame recovery is the system's responsibility.

## Timing
- Reset values: `ad1`=0, `ad2`=0, `ad_valid`=0, `busy`=0, `frame_done`=0, `overrange`=0. State is IDLE and all counters and the window are zero.
- Latency is 1 cycle: a strobe at cycle N gives `ad_valid`, `ad1` and `ad2` at N+1. All outputs are registered.
- The detection decision is made combinationally on the strobe cycle, so the trigger sample appears at N+1 like any other.
- `frame_done` is high in the same cycle as the final `ad_valid`.
- `busy` rises the cycle after `arm`. It falls in the cycle of `frame_done`, unless auto-rearm is enabled.
- No backpressure: `ad_valid` follows `adc_strobe` exactly. The downstream FIFO absorbs the rate.

## Configuration
- `AD_CAPTURE_AUTOREARM_EN`:
  - Defined: after the last sample the FSM goes straight to ARMED. The window and fill counter are cleared and `overrange` is kept. `busy` stays high.
  - Undefined: the FSM returns to IDLE and waits for `arm`.

## Structure
- Package `ad_capture_pkg` holds:
  - state enum (IDLE, ARMED, CAPTURE);
  - `SYM_LEN`=64;
  - `WIN_LOG2`=4;
  - `MAG_W`=9 and `ENERGY_W`=13;
  - sample counter width 14.
- Sub-module `ad_energy_win`: a 16-deep shift register of 9-bit magnitudes with a running-sum accumulator. Interface: clear, strobe, magnitude in; energy and window-valid out.

## Test plan
- Reset then `arm`; 20 strobes of 0x80/0x80, then noise → no `ad_valid`, `busy`=1, energy stays below threshold.
- `arm`; 16 strobes of 0x80, then a constant 0xC0/0xC0 tone (magnitude 128) → energy crosses 64 on the first tone strobe. That sample appears as `ad1`=`ad2`=0x40 one cycle later.
- `NSYM`=2 capture with a continuous strobe → exactly 128 `ad_valid` cycles. `frame_done` coincides with the 128th, and `busy` falls the same cycle.
- A raw 0xFF on I mid-capture → `overrange` rises the cycle after and persists through IDLE. The next `arm` clears it.
- `RST` low at capture sample 50 → all outputs 0 asynchronously; after release, no `frame_done` and state is IDLE.
- With `AD_CAPTURE_AUTOREARM_EN` and two back-to-back bursts → two frames of 1024 samples each, with `busy` continuously high.
